// File: rtl/cam_alloc_ctrl_if.sv
// cam_alloc_ctrl_if: command/response handshake plus CAM write port bundle
// for cam_alloc_ctrl.
//   cmd_*       : command request (INSERT / DELETE / FLUSH)
//   rsp_*       : single response per accepted command
//   cam_write_* : write port toward the CAM array (busy comes back from the CAM)
// slave  = controller side, master = requester / CAM side.
interface cam_alloc_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_status;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    logic [ADDR_WIDTH-1:0] cam_write_addr;
    logic [DATA_WIDTH-1:0] cam_write_data;
    logic                  cam_write_delete;
    logic                  cam_write_enable;
    logic                  cam_write_busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_addr, rsp_ready, cam_write_busy,
        output cmd_ready, rsp_valid, rsp_status, rsp_addr,
               cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_addr, rsp_ready, cam_write_busy,
        input  cmd_ready, rsp_valid, rsp_status, rsp_addr,
               cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable
    );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// cam_alloc_ctrl: allocation controller for an N-entry CAM.
// Tracks which entries are in use, allocates the lowest free entry on INSERT,
// frees an entry on DELETE and walks the whole table on FLUSH, issuing one
// CAM write at a time and returning one response per command.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : cmd/rsp handshake and CAM write port (slave modport)
//   entry_valid : per-entry in-use bitmap
//   count       : number of in-use entries (0..N)
//   full, empty : count == N / count == 0
module cam_alloc_ctrl #(
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 5,
    localparam int N          = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    cam_alloc_ctrl_if.slave       bus,
    output logic [N-1:0]          entry_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam logic [1:0] OP_INSERT  = 2'b00;
    localparam logic [1:0] OP_DELETE  = 2'b01;
    localparam logic [1:0] OP_FLUSH   = 2'b10;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FULL    = 2'b01;
    localparam logic [1:0] ST_INVALID = 2'b10;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCAN, RESP} state_t;

    state_t                state, state_nxt;
    logic                  flush_q, flush_nxt;   // current command is a FLUSH walk
    logic                  first_q, first_nxt;   // first WAIT cycle, busy ignored
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_nxt;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_nxt;
    logic                  wr_del_q, wr_del_nxt;
    logic [1:0]            rsp_status_q, rsp_status_nxt;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_nxt;
    logic [N-1:0]          ev_nxt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] free_idx;
    logic [ADDR_WIDTH:0]   count_c;

    // Lowest-index free entry: scan downward so the last hit wins.
    always_comb begin
        free_idx = '0;
        for (int i = N-1; i >= 0; i--)
            if (!entry_valid[i]) free_idx = ADDR_WIDTH'(i);
    end

    always_comb begin
        count_c = '0;
        for (int i = 0; i < N; i++)
            count_c = count_c + (ADDR_WIDTH+1)'(entry_valid[i]);
    end

    assign count = count_c;
    assign full  = (count_c == (ADDR_WIDTH+1)'(N));
    assign empty = (count_c == '0);

    // cmd_ready is gated by rst so it reads 0 while reset is held even
    // though the state register already sits in IDLE.
    assign bus.cmd_ready        = (state == IDLE) && rst;
    assign bus.rsp_valid        = (state == RESP);
    assign bus.rsp_status       = rsp_status_q;
    assign bus.rsp_addr         = rsp_addr_q;
    assign bus.cam_write_addr   = wr_addr_q;
    assign bus.cam_write_data   = wr_data_q;
    assign bus.cam_write_delete = wr_del_q;
    assign bus.cam_write_enable = wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            flush_q      <= 1'b0;
            first_q      <= 1'b0;
            ptr_q        <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_del_q     <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_addr_q   <= '0;
            entry_valid  <= '0;
        end else begin
            state        <= state_nxt;
            flush_q      <= flush_nxt;
            first_q      <= first_nxt;
            ptr_q        <= ptr_nxt;
            wr_addr_q    <= wr_addr_nxt;
            wr_data_q    <= wr_data_nxt;
            wr_del_q     <= wr_del_nxt;
            rsp_status_q <= rsp_status_nxt;
            rsp_addr_q   <= rsp_addr_nxt;
            entry_valid  <= ev_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_nxt      = flush_q;
        first_nxt      = first_q;
        ptr_nxt        = ptr_q;
        wr_addr_nxt    = wr_addr_q;
        wr_data_nxt    = wr_data_q;
        wr_del_nxt     = wr_del_q;
        rsp_status_nxt = rsp_status_q;
        rsp_addr_nxt   = rsp_addr_q;
        ev_nxt         = entry_valid;
        wr_en          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    flush_nxt      = 1'b0;
                    rsp_status_nxt = ST_OK;
                    rsp_addr_nxt   = '0;
                    case (bus.cmd_op)
                        OP_INSERT: begin
                            if (full) begin
                                rsp_status_nxt = ST_FULL;
                                state_nxt      = RESP;
                            end else begin
                                wr_addr_nxt = free_idx;
                                wr_data_nxt = bus.cmd_data;
                                wr_del_nxt  = 1'b0;
                                state_nxt   = ISSUE;
                            end
                        end
                        OP_DELETE: begin
                            if (entry_valid[bus.cmd_addr]) begin
                                wr_addr_nxt = bus.cmd_addr;
                                wr_data_nxt = '0;
                                wr_del_nxt  = 1'b1;
                                state_nxt   = ISSUE;
                            end else begin
                                rsp_status_nxt = ST_INVALID;
                                state_nxt      = RESP;
                            end
                        end
                        OP_FLUSH: begin
                            flush_nxt = 1'b1;
                            ptr_nxt   = '0;
                            state_nxt = SCAN;
                        end
                        default: begin
                            rsp_status_nxt = ST_INVALID;
                            state_nxt      = RESP;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (!bus.cam_write_busy) begin
                    wr_en     = 1'b1;
                    first_nxt = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // The CAM may not raise busy until the cycle after enable,
                // so the first WAIT cycle never completes the write.
                if (first_q) begin
                    first_nxt = 1'b0;
                end else if (!bus.cam_write_busy) begin
                    ev_nxt[wr_addr_q] = !wr_del_q;
                    if (flush_q) begin
                        if (&ptr_q) begin
                            state_nxt = RESP;
                        end else begin
                            ptr_nxt   = ptr_q + 1'b1;
                            state_nxt = SCAN;
                        end
                    end else begin
                        rsp_addr_nxt = wr_addr_q;
                        state_nxt    = RESP;
                    end
                end
            end
            SCAN: begin
                if (entry_valid[ptr_q]) begin
                    wr_addr_nxt = ptr_q;
                    wr_data_nxt = '0;
                    wr_del_nxt  = 1'b1;
                    state_nxt   = ISSUE;
                end else if (&ptr_q) begin
                    state_nxt = RESP;
                end else begin
                    ptr_nxt = ptr_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Directed bench for cam_alloc_ctrl with N=4 and a CAM model that holds
// busy for two cycles after each write enable.
module tb_cam_alloc_ctrl;
    localparam int DW = 64;
    localparam int AW = 2;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cam_alloc_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    logic [N-1:0] entry_valid;
    logic [AW:0]  count;
    logic         full, empty;

    cam_alloc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .entry_valid(entry_valid), .count(count), .full(full), .empty(empty)
    );

    int checks = 0;
    int errors = 0;

    // CAM busy model plus a forced-busy input for stall tests.
    int   busy_cnt;
    logic busy_force;
    always @(posedge clk or negedge rst) begin
        if (!rst) busy_cnt <= 0;
        else if (bus.cam_write_enable) busy_cnt <= 2;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.cam_write_busy = (busy_cnt != 0) || busy_force;

    // Write pulse log.
    int            pulses = 0;
    logic [AW-1:0] p_addr [64];
    logic          p_del  [64];
    logic [DW-1:0] p_data [64];
    always @(posedge clk) begin
        if (rst && bus.cam_write_enable && pulses < 64) begin
            p_addr[pulses] <= bus.cam_write_addr;
            p_del[pulses]  <= bus.cam_write_delete;
            p_data[pulses] <= bus.cam_write_data;
            pulses         <= pulses + 1;
        end
    end

    // Called at a negedge; returns just after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] data, input logic [AW-1:0] addr);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data; bus.cmd_addr = addr;
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed %0b, required 1", bus.cmd_ready);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Counts negedges after the accepting edge until rsp_valid is seen.
    task automatic wait_rsp(output logic [1:0] st, output logic [AW-1:0] ad, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 200);
        if (!bus.rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0 after %0d cycles", lat);
        end
        st = bus.rsp_status; ad = bus.rsp_addr;
    endtask

    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] data, input logic [AW-1:0] addr,
                          output logic [1:0] st, output logic [AW-1:0] ad, output int lat);
        send_cmd(op, data, addr);
        wait_rsp(st, ad, lat);
        ack_rsp();
    endtask

    logic [1:0]    st;
    logic [AW-1:0] ad;
    int            lat;
    int            p0;

    task automatic test_reset();
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_data = 0; bus.cmd_addr = 0;
        bus.rsp_ready = 0; busy_force = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %0b, required 0", bus.cmd_ready); end
        checks++; if ({bus.rsp_valid, bus.cam_write_enable} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b, required 00", {bus.rsp_valid, bus.cam_write_enable}); end
        checks++; if ({entry_valid, count, empty, full} !== {4'h0, 3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL reset_status: got ev=%h cnt=%0d e=%b f=%b, required ev=0 cnt=0 e=1 f=0", entry_valid, count, empty, full); end
        checks++; if ({bus.cam_write_addr, bus.cam_write_data, bus.cam_write_delete, bus.rsp_status, bus.rsp_addr} !== '0) begin errors++; $display("FAIL reset_data: cam/rsp data outputs not all zero"); end
        rst = 1'b1;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b, required 1", bus.cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_insert_fill();
        for (int k = 0; k < 4; k++) begin
            p0 = pulses;
            do_cmd(2'b00, 64'hA + 64'(k), '0, st, ad, lat);
            checks++; if (st !== 2'b00 || ad !== AW'(k)) begin errors++; $display("FAIL insert_rsp_%0d: got st=%0d addr=%0d, required st=0 addr=%0d", k, st, ad, k); end
            checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL insert_pulses_%0d: got %0d, required %0d", k, pulses - p0, 1); end
            checks++; if (p_addr[p0] !== AW'(k) || p_del[p0] !== 1'b0 || p_data[p0] !== 64'hA + 64'(k)) begin errors++; $display("FAIL insert_write_%0d: got a=%0d d=%b data=%h, required a=%0d d=0 data=%h", k, p_addr[p0], p_del[p0], p_data[p0], k, 64'hA + 64'(k)); end
            checks++; if (lat !== 5) begin errors++; $display("FAIL insert_latency_%0d: got %0d, required 5", k, lat); end
        end
        checks++; if ({entry_valid, count, full, empty} !== {4'hF, 3'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL fill_status: got ev=%h cnt=%0d f=%b e=%b, required ev=f cnt=4 f=1 e=0", entry_valid, count, full, empty); end
        p0 = pulses;
        do_cmd(2'b00, 64'hF, '0, st, ad, lat);
        checks++; if (st !== 2'b01 || ad !== '0) begin errors++; $display("FAIL insert_full_rsp: got st=%0d addr=%0d, required st=1 addr=0", st, ad); end
        checks++; if (pulses !== p0 || lat !== 1) begin errors++; $display("FAIL insert_full_nowrite: got pulses=%0d lat=%0d, required 0 and 1", pulses - p0, lat); end
    endtask

    task automatic test_delete_reinsert();
        p0 = pulses;
        do_cmd(2'b01, '0, 2'd1, st, ad, lat);
        checks++; if (st !== 2'b00 || ad !== 2'd1) begin errors++; $display("FAIL delete_rsp: got st=%0d addr=%0d, required st=0 addr=1", st, ad); end
        checks++; if (pulses !== p0 + 1 || p_addr[p0] !== 2'd1 || p_del[p0] !== 1'b1) begin errors++; $display("FAIL delete_write: got n=%0d a=%0d d=%b, required n=1 a=1 d=1", pulses - p0, p_addr[p0], p_del[p0]); end
        checks++; if (entry_valid !== 4'hD || count !== 3'd3) begin errors++; $display("FAIL delete_status: got ev=%h cnt=%0d, required ev=d cnt=3", entry_valid, count); end
        p0 = pulses;
        do_cmd(2'b00, 64'hE, '0, st, ad, lat);
        checks++; if (st !== 2'b00 || ad !== 2'd1) begin errors++; $display("FAIL reinsert_rsp: got st=%0d addr=%0d, required st=0 addr=1", st, ad); end
        checks++; if (pulses !== p0 + 1 || p_addr[p0] !== 2'd1 || p_del[p0] !== 1'b0 || p_data[p0] !== 64'hE) begin errors++; $display("FAIL reinsert_write: got n=%0d a=%0d d=%b data=%h, required n=1 a=1 d=0 data=e", pulses - p0, p_addr[p0], p_del[p0], p_data[p0]); end
        checks++; if (entry_valid !== 4'hF) begin errors++; $display("FAIL reinsert_ev: got %h, required f", entry_valid); end
    endtask

    task automatic test_invalid();
        do_cmd(2'b01, '0, 2'd2, st, ad, lat);
        checks++; if (st !== 2'b00 || ad !== 2'd2) begin errors++; $display("FAIL delete2_rsp: got st=%0d addr=%0d, required st=0 addr=2", st, ad); end
        p0 = pulses;
        do_cmd(2'b01, '0, 2'd2, st, ad, lat);
        checks++; if (st !== 2'b10 || ad !== '0 || pulses !== p0 || lat !== 1) begin errors++; $display("FAIL delete_invalid: got st=%0d addr=%0d n=%0d lat=%0d, required st=2 addr=0 n=0 lat=1", st, ad, pulses - p0, lat); end
        do_cmd(2'b11, 64'h5, 2'd3, st, ad, lat);
        checks++; if (st !== 2'b10 || ad !== '0 || pulses !== p0) begin errors++; $display("FAIL op11_invalid: got st=%0d addr=%0d n=%0d, required st=2 addr=0 n=0", st, ad, pulses - p0); end
        checks++; if (entry_valid !== 4'hB) begin errors++; $display("FAIL invalid_ev: got %h, required b", entry_valid); end
    endtask

    task automatic test_flush();
        do_cmd(2'b01, '0, 2'd1, st, ad, lat);
        checks++; if (entry_valid !== 4'h9) begin errors++; $display("FAIL preflush_ev: got %h, required 9", entry_valid); end
        p0 = pulses;
        do_cmd(2'b10, '0, '0, st, ad, lat);
        checks++; if (st !== 2'b00 || ad !== '0) begin errors++; $display("FAIL flush_rsp: got st=%0d addr=%0d, required st=0 addr=0", st, ad); end
        checks++; if (pulses !== p0 + 2) begin errors++; $display("FAIL flush_pulses: got %0d, required 2", pulses - p0); end
        checks++; if (p_addr[p0] !== 2'd0 || p_addr[p0+1] !== 2'd3 || p_del[p0] !== 1'b1 || p_del[p0+1] !== 1'b1) begin errors++; $display("FAIL flush_order: got a0=%0d a1=%0d d=%b%b, required 0,3 d=11", p_addr[p0], p_addr[p0+1], p_del[p0], p_del[p0+1]); end
        checks++; if (lat !== 13) begin errors++; $display("FAIL flush_latency: got %0d, required 13", lat); end
        checks++; if ({entry_valid, count, empty} !== {4'h0, 3'd0, 1'b1}) begin errors++; $display("FAIL flush_status: got ev=%h cnt=%0d e=%b, required 0 0 1", entry_valid, count, empty); end
        p0 = pulses;
        do_cmd(2'b10, '0, '0, st, ad, lat);
        checks++; if (st !== 2'b00 || pulses !== p0 || lat !== 5) begin errors++; $display("FAIL flush_empty: got st=%0d n=%0d lat=%0d, required st=0 n=0 lat=5", st, pulses - p0, lat); end
    endtask

    task automatic test_busy_stall();
        p0 = pulses;
        busy_force = 1'b1;
        send_cmd(2'b00, 64'h55, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.cam_write_enable !== 1'b0 || bus.cam_write_addr !== 2'd0 || bus.cam_write_data !== 64'h55) begin errors++; $display("FAIL stall_hold_%0d: got en=%b a=%0d data=%h, required en=0 a=0 data=55", c, bus.cam_write_enable, bus.cam_write_addr, bus.cam_write_data); end
        end
        busy_force = 1'b0;
        wait_rsp(st, ad, lat);
        checks++; if (st !== 2'b00 || ad !== 2'd0) begin errors++; $display("FAIL stall_rsp: got st=%0d addr=%0d, required 0 0", st, ad); end
        checks++; if (pulses !== p0 + 1 || p_data[p0] !== 64'h55) begin errors++; $display("FAIL stall_pulse: got n=%0d data=%h, required n=1 data=55", pulses - p0, p_data[p0]); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({bus.rsp_valid, bus.rsp_status, bus.rsp_addr, bus.cmd_ready} !== {1'b1, 2'b00, 2'd0, 1'b0}) begin errors++; $display("FAIL rsp_hold_%0d: got v=%b st=%0d a=%0d rdy=%b, required v=1 st=0 a=0 rdy=0", c, bus.rsp_valid, bus.rsp_status, bus.rsp_addr, bus.cmd_ready); end
        end
        ack_rsp();
        checks++; if (count !== 3'd1 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_after: got cnt=%0d rdy=%b, required 1 1", count, bus.cmd_ready); end
    endtask

    task automatic test_reset_mid_write();
        send_cmd(2'b00, 64'h77, '0);
        @(negedge clk);
        checks++; if (bus.cam_write_enable !== 1'b1 || bus.cam_write_addr !== 2'd1) begin errors++; $display("FAIL midwrite_issue: got en=%b a=%0d, required en=1 a=1", bus.cam_write_enable, bus.cam_write_addr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({bus.cam_write_enable, bus.rsp_valid, bus.cmd_ready, empty, full} !== 5'b00010) begin errors++; $display("FAIL midwrite_reset_ctrl: got %b, required 00010", {bus.cam_write_enable, bus.rsp_valid, bus.cmd_ready, empty, full}); end
        checks++; if ({entry_valid, count} !== '0) begin errors++; $display("FAIL midwrite_reset_ev: got ev=%h cnt=%0d, required 0 0", entry_valid, count); end
        checks++; if ({bus.cam_write_addr, bus.cam_write_data, bus.cam_write_delete, bus.rsp_status, bus.rsp_addr} !== '0) begin errors++; $display("FAIL midwrite_reset_data: data outputs not zero, a=%0d data=%h", bus.cam_write_addr, bus.cam_write_data); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midwrite_no_rsp_%0d: got %b, required 0", c, bus.rsp_valid); end
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midwrite_release_ready: got %b, required 1", bus.cmd_ready); end
        @(negedge clk);
        do_cmd(2'b00, 64'h88, '0, st, ad, lat);
        checks++; if (st !== 2'b00 || ad !== 2'd0 || entry_valid !== 4'h1) begin errors++; $display("FAIL post_reset_insert: got st=%0d a=%0d ev=%h, required 0 0 1", st, ad, entry_valid); end
    endtask

    initial begin
        test_reset();
        test_insert_fill();
        test_delete_reinsert();
        test_invalid();
        test_flush();
        test_busy_stall();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
